// File: rtl/washer_ctrl.sv
// Washer sequencer: fill / wash / drain / rinse / spin with door-fault and abort handling.
// Actuator outputs are Moore-decoded from the state register; cycle_done is registered.
module washer_ctrl #(
  parameter int WASH_CYCLES  = 5,
  parameter int RINSE_CYCLES = 3,
  parameter int DRAIN_CYCLES = 2,
  parameter int SPIN_CYCLES  = 4,
  parameter int FILL_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       door_closed,
  input  logic       water_full,
  input  logic       abort,
  output logic       fill_valve,
  output logic       drain_valve,
  output logic       motor_on,
  output logic       spin_hi,
  output logic       door_lock,
  output logic [2:0] phase,
  output logic       cycle_done,
  output logic       fault
);

  localparam int MAX_WR = (WASH_CYCLES > RINSE_CYCLES) ? WASH_CYCLES : RINSE_CYCLES;
  localparam int MAX_DS = (DRAIN_CYCLES > SPIN_CYCLES) ? DRAIN_CYCLES : SPIN_CYCLES;
  localparam int MAX_4  = (MAX_WR > MAX_DS) ? MAX_WR : MAX_DS;
  localparam int MAX_C  = (MAX_4 > FILL_TIMEOUT) ? MAX_4 : FILL_TIMEOUT;
  localparam int TW     = $clog2(MAX_C) + 1;

  localparam logic [TW-1:0] WASH_LAST  = TW'(WASH_CYCLES - 1);
  localparam logic [TW-1:0] RINSE_LAST = TW'(RINSE_CYCLES - 1);
  localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_CYCLES - 1);
  localparam logic [TW-1:0] SPIN_LAST  = TW'(SPIN_CYCLES - 1);
  localparam logic [TW-1:0] FILL_LAST  = TW'(FILL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    DRAIN = 3'd3,
    RINSE = 3'd4,
    SPIN  = 3'd5,
    FAULT = 3'd6
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic          rinse_flag;
  logic          abort_flag;
  logic          abort_take;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      timer      <= '0;
      rinse_flag <= 1'b0;
      abort_flag <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) timer <= '0;
      else                    timer <= timer + TW'(1);
      cycle_done <= (state == SPIN) && (state_nxt == IDLE);
      // Both flags describe the current wash run only; leaving the run drops them.
      if (state_nxt == IDLE || state_nxt == FAULT) begin
        rinse_flag <= 1'b0;
        abort_flag <= 1'b0;
      end else begin
        if (state == DRAIN && state_nxt == FILL) rinse_flag <= 1'b1;
        if (abort_take) abort_flag <= 1'b1;
      end
    end
  end

  // Door fault outranks abort, which outranks fill timeout and normal exits.
  always_comb begin
    state_nxt  = state;
    abort_take = 1'b0;
    case (state)
      IDLE: if (start && door_closed) state_nxt = FILL;
      FILL: begin
        if (!door_closed)    state_nxt = FAULT;
        else if (abort)      begin state_nxt = DRAIN; abort_take = 1'b1; end
        else if (water_full) state_nxt = rinse_flag ? RINSE : WASH;
        else if (timer == FILL_LAST) state_nxt = FAULT;
      end
      WASH: begin
        if (!door_closed)            state_nxt = FAULT;
        else if (abort)              begin state_nxt = DRAIN; abort_take = 1'b1; end
        else if (timer == WASH_LAST) state_nxt = DRAIN;
      end
      RINSE: begin
        if (!door_closed)             state_nxt = FAULT;
        else if (abort)               begin state_nxt = DRAIN; abort_take = 1'b1; end
        else if (timer == RINSE_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!door_closed) state_nxt = FAULT;
        else if (timer == DRAIN_LAST) begin
          if (abort_flag)      state_nxt = IDLE;
          else if (rinse_flag) state_nxt = SPIN;
          else                 state_nxt = FILL;
        end
      end
      SPIN: begin
        if (!door_closed)            state_nxt = FAULT;
        else if (abort)              begin state_nxt = DRAIN; abort_take = 1'b1; end
        else if (timer == SPIN_LAST) state_nxt = IDLE;
      end
      FAULT: if (abort && door_closed) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign phase       = state;
  assign fill_valve  = (state == FILL);
  assign motor_on    = (state == WASH) || (state == RINSE) || (state == SPIN);
  assign spin_hi     = (state == SPIN);
  assign drain_valve = (state == DRAIN) || (state == SPIN);
  assign door_lock   = (state == FILL) || (state == WASH) || (state == DRAIN) ||
                       (state == RINSE) || (state == SPIN);
  assign fault       = (state == FAULT);

endmodule

// File: tb/tb_washer_ctrl.sv
// Directed bench for washer_ctrl with default parameters; immediate assertions at each check.
module tb_washer_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       door_closed;
  logic       water_full;
  logic       abort;
  logic       fill_valve;
  logic       drain_valve;
  logic       motor_on;
  logic       spin_hi;
  logic       door_lock;
  logic [2:0] phase;
  logic       cycle_done;
  logic       fault;

  int tests = 0;
  int fails = 0;

  int ph_tab  [7] = '{1, 2, 3, 1, 4, 3, 5};
  int len_tab [7] = '{2, 5, 2, 2, 3, 2, 4};

  washer_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start), .door_closed(door_closed),
    .water_full(water_full), .abort(abort), .fill_valve(fill_valve),
    .drain_valve(drain_valve), .motor_on(motor_on), .spin_hi(spin_hi),
    .door_lock(door_lock), .phase(phase), .cycle_done(cycle_done), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {fill, drain, motor, spin_hi, door_lock, fault} for a phase code.
  function automatic logic [5:0] exp_outs(input int ph);
    return {ph == 1, (ph == 3) || (ph == 5), (ph == 2) || (ph == 4) || (ph == 5),
            ph == 5, (ph >= 1) && (ph <= 5), ph == 6};
  endfunction

  function automatic logic [5:0] obs_outs();
    return {fill_valve, drain_valve, motor_on, spin_hi, door_lock, fault};
  endfunction

  task automatic chk_state(input string tag, input int ph);
    chk({tag, "_phase"}, 32'(phase), 32'(ph));
    chk({tag, "_outs"}, 32'(obs_outs()), 32'(exp_outs(ph)));
  endtask

  // Walks the first nent phases of the normal run; the last one only last_len cycles.
  task automatic run_seq(input int nent, input int last_len, input bit hold_start);
    start = 1'b1;
    for (int k = 0; k < nent; k++) begin
      int n;
      n = (k == nent - 1) ? last_len : len_tab[k];
      for (int i = 0; i < n; i++) begin
        step();
        chk_state($sformatf("seq_k%0d_i%0d", k, i), ph_tab[k]);
        chk($sformatf("seq_done_k%0d_i%0d", k, i), 32'(cycle_done), 32'd0);
        if (!hold_start) start = 1'b0;
        water_full = (ph_tab[k] == 1) && (i == 1);
      end
    end
    water_full = 1'b0;
  endtask

  initial begin
    rstn = 1'b1; start = 1'b0; door_closed = 1'b1; water_full = 1'b0; abort = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk_state("reset", 0);
    chk("reset_done", 32'(cycle_done), 32'd0);
    step(); step();
    rstn = 1'b1;
    step();
    chk_state("post_reset", 0);

    // Start with the door open never leaves IDLE.
    start = 1'b1; door_closed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_state($sformatf("door_open_%0d", i), 0);
    end
    start = 1'b0; door_closed = 1'b1;

    // Full normal run.
    run_seq(7, 4, 1'b0);
    step();
    chk_state("done_idle", 0);
    chk("done_pulse", 32'(cycle_done), 32'd1);
    step();
    chk("done_pulse_end", 32'(cycle_done), 32'd0);

    // Start held through completion: one IDLE cycle, then FILL again.
    run_seq(7, 4, 1'b1);
    step();
    chk_state("hold_idle", 0);
    chk("hold_pulse", 32'(cycle_done), 32'd1);
    step();
    chk_state("hold_refill", 1);
    chk("hold_pulse_end", 32'(cycle_done), 32'd0);
    start = 1'b0; abort = 1'b1;
    step();
    chk_state("fill_abort_drain0", 3);
    step();
    chk_state("fill_abort_drain1", 3);
    abort = 1'b0;
    step();
    chk_state("fill_abort_idle", 0);
    chk("fill_abort_nodone", 32'(cycle_done), 32'd0);

    // Fill timeout to FAULT, then clear.
    start = 1'b1;
    step();
    chk_state("to_fill0", 1);
    start = 1'b0;
    for (int i = 1; i < 8; i++) begin
      step();
      chk_state($sformatf("to_fill%0d", i), 1);
    end
    step();
    chk_state("to_fault", 6);
    step();
    chk_state("to_fault_hold", 6);
    abort = 1'b1; door_closed = 1'b0;
    step();
    chk_state("to_fault_door_open", 6);
    door_closed = 1'b1;
    step();
    chk_state("to_fault_clear", 0);
    abort = 1'b0;

    // Abort on the third WASH cycle.
    run_seq(2, 3, 1'b0);
    abort = 1'b1;
    step();
    chk_state("wash_abort_drain0", 3);
    abort = 1'b0;
    step();
    chk_state("wash_abort_drain1", 3);
    step();
    chk_state("wash_abort_idle", 0);
    chk("wash_abort_nodone0", 32'(cycle_done), 32'd0);
    step();
    chk("wash_abort_nodone1", 32'(cycle_done), 32'd0);

    // Door open and abort together in SPIN: door wins.
    run_seq(7, 1, 1'b0);
    door_closed = 1'b0; abort = 1'b1;
    step();
    chk_state("spin_door_fault", 6);
    door_closed = 1'b1;
    step();
    chk_state("spin_fault_clear", 0);
    abort = 1'b0;

    // Asynchronous reset between edges mid-WASH.
    run_seq(2, 2, 1'b0);
    #3 rstn = 1'b0;
    #1;
    chk("async_phase", 32'(phase), 32'd0);
    chk("async_motor", 32'(motor_on), 32'd0);
    chk("async_lock", 32'(door_lock), 32'd0);
    step();
    chk_state("async_held", 0);
    rstn = 1'b1;
    step();
    chk_state("async_release", 0);

    // Normal run again after reset.
    run_seq(7, 4, 1'b0);
    step();
    chk_state("rerun_idle", 0);
    chk("rerun_pulse", 32'(cycle_done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
